// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: write controller and round-robin arbiter for a bank of
// DEPTH transparent D-latches. Two requesters share the bank. Each write runs
// as SETUP -> ENABLE (EN_CYC cycles) -> HOLD -> DONE, so LD is always stable
// while any LE bit is high. All outputs are registered.
//
// Optional build macro: LATCH_BANK_CTRL_ERR_EN adds an ERR output. ERR pulses
// together with ACK when the serviced address was outside the bank.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; arbitration and capture happen here
// S_SETUP  | LD driven with captured data, all LE low
// S_ENABLE | LE[addr] high for EN_CYC cycles (down-counter), LD stable
// S_HOLD   | LE low again, LD still stable
// S_DONE   | ACK pulse to the granted requester
module latch_bank_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int EN_CYC = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [WIDTH-1:0]  DATA0,
    input  logic              REQ1,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [WIDTH-1:0]  DATA1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DEPTH-1:0]  LE,
    output logic [WIDTH-1:0]  LD,
`ifdef LATCH_BANK_CTRL_ERR_EN
    output logic              ERR,
`endif
    output logic              BUSY
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ENABLE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [3:0] CNT_LOAD = 4'(EN_CYC - 1);

    logic [2:0]        state;
    logic              last;      // requester granted most recently
    logic              gnt_q;     // requester being serviced
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        cnt;
    logic [DEPTH-1:0]  le_dec;
    logic              gnt_valid;
    logic              gnt_sel;

    // Round-robin pick: a lone request wins outright, a tie goes to the
    // requester that was not granted last time.
    always_comb begin
        gnt_valid = REQ0 | REQ1;
        if (REQ0 && REQ1) begin
            gnt_sel = ~last;
        end else begin
            gnt_sel = REQ1;
        end
    end

    // One-hot decode of the captured address; an out-of-range address
    // decodes to all zeros so no latch is ever opened for it.
    always_comb begin
        le_dec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                le_dec[i] = 1'b1;
            end
        end
    end

    // Write sequencer: arbitration, capture and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            last   <= 1'b1;
            gnt_q  <= 1'b0;
            addr_q <= '0;
            cnt    <= '0;
            LE     <= '0;
            LD     <= '0;
            ACK0   <= 1'b0;
            ACK1   <= 1'b0;
            BUSY   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt_valid) begin
                        gnt_q  <= gnt_sel;
                        last   <= gnt_sel;
                        addr_q <= gnt_sel ? ADDR1 : ADDR0;
                        LD     <= gnt_sel ? DATA1 : DATA0;
                        BUSY   <= 1'b1;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    LE    <= le_dec;
                    cnt   <= CNT_LOAD;
                    state <= S_ENABLE;
                end
                S_ENABLE: begin
                    if (cnt == 4'd0) begin
                        LE    <= '0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    ACK0  <= ~gnt_q;
                    ACK1  <= gnt_q;
                    state <= S_DONE;
                end
                S_DONE: begin
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    LE    <= '0;
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LATCH_BANK_CTRL_ERR_EN
    // Error flag: raised on entry to DONE alongside ACK when the captured
    // address selected no latch, cleared on the following edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else begin
            ERR <= (state == S_HOLD) && (le_dec == '0);
        end
    end
`else
    // Without the error flag an out-of-range write simply completes with
    // LE held at zero and an ordinary ACK.
`endif

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Self-checking bench for latch_bank_ctrl. Instance a uses the default
// parameters (DEPTH=4, EN_CYC=1); instance b uses DEPTH=3, EN_CYC=3 to cover
// multi-cycle enables and out-of-range addresses.
module tb_latch_bank_ctrl;

    typedef struct {
        logic       req0;
        logic [1:0] addr0;
        logic [7:0] data0;
        logic       req1;
        logic [1:0] addr1;
        logic [7:0] data1;
        logic       ack0;
        logic       ack1;
        logic [3:0] le;
        logic [7:0] ld;
        logic       busy;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;

    logic       a_req0 = 0, a_req1 = 0;
    logic [1:0] a_addr0 = 0, a_addr1 = 0;
    logic [7:0] a_data0 = 0, a_data1 = 0;
    logic       a_ack0, a_ack1, a_busy;
    logic [3:0] a_le;
    logic [7:0] a_ld;

    logic       b_req0 = 0, b_req1 = 0;
    logic [1:0] b_addr0 = 0, b_addr1 = 0;
    logic [7:0] b_data0 = 0, b_data1 = 0;
    logic       b_ack0, b_ack1, b_busy;
    logic [2:0] b_le;
    logic [7:0] b_ld;
`ifdef LATCH_BANK_CTRL_ERR_EN
    logic       a_err, b_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    latch_bank_ctrl #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .EN_CYC(1)) dut_a (
        .CLK(CLK), .RST(RST),
        .REQ0(a_req0), .ADDR0(a_addr0), .DATA0(a_data0),
        .REQ1(a_req1), .ADDR1(a_addr1), .DATA1(a_data1),
        .ACK0(a_ack0), .ACK1(a_ack1), .LE(a_le), .LD(a_ld),
`ifdef LATCH_BANK_CTRL_ERR_EN
        .ERR(a_err),
`endif
        .BUSY(a_busy)
    );

    latch_bank_ctrl #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .EN_CYC(3)) dut_b (
        .CLK(CLK), .RST(RST),
        .REQ0(b_req0), .ADDR0(b_addr0), .DATA0(b_data0),
        .REQ1(b_req1), .ADDR1(b_addr1), .DATA1(b_data1),
        .ACK0(b_ack0), .ACK1(b_ack1), .LE(b_le), .LD(b_ld),
`ifdef LATCH_BANK_CTRL_ERR_EN
        .ERR(b_err),
`endif
        .BUSY(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic a_chk(input string tag, input logic ack0, input logic ack1,
                         input logic [3:0] le, input logic [7:0] ld, input logic busy);
        chk({tag, ".ack0"}, 32'(a_ack0), 32'(ack0));
        chk({tag, ".ack1"}, 32'(a_ack1), 32'(ack1));
        chk({tag, ".le"},   32'(a_le),   32'(le));
        chk({tag, ".ld"},   32'(a_ld),   32'(ld));
        chk({tag, ".busy"}, 32'(a_busy), 32'(busy));
    endtask

    task automatic b_chk(input string tag, input logic ack0, input logic ack1,
                         input logic [2:0] le, input logic [7:0] ld, input logic busy);
        chk({tag, ".ack0"}, 32'(b_ack0), 32'(ack0));
        chk({tag, ".ack1"}, 32'(b_ack1), 32'(ack1));
        chk({tag, ".le"},   32'(b_le),   32'(le));
        chk({tag, ".ld"},   32'(b_ld),   32'(ld));
        chk({tag, ".busy"}, 32'(b_busy), 32'(busy));
    endtask

    function automatic vec_t mk(input logic r0, input logic [1:0] ad0, input logic [7:0] d0,
                                input logic r1, input logic [1:0] ad1, input logic [7:0] d1,
                                input logic k0, input logic k1, input logic [3:0] le,
                                input logic [7:0] ld, input logic busy);
        vec_t v;
        v.req0 = r0; v.addr0 = ad0; v.data0 = d0;
        v.req1 = r1; v.addr1 = ad1; v.data1 = d1;
        v.ack0 = k0; v.ack1 = k1; v.le = le; v.ld = ld; v.busy = busy;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        a_req0 = v.req0; a_addr0 = v.addr0; a_data0 = v.data0;
        a_req1 = v.req1; a_addr1 = v.addr1; a_data1 = v.data1;
        tick();
        a_chk($sformatf("vec%0d", idx), v.ack0, v.ack1, v.le, v.ld, v.busy);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   t1_len;

        // Single write, EN_CYC=1: SETUP, ENABLE, HOLD, DONE, back to IDLE.
        tbl.push_back(mk(1, 2, 8'hA5, 0, 0, 8'h00, 0, 0, 4'b0000, 8'hA5, 1));
        tbl.push_back(mk(1, 2, 8'hA5, 0, 0, 8'h00, 0, 0, 4'b0100, 8'hA5, 1));
        tbl.push_back(mk(1, 2, 8'hA5, 0, 0, 8'h00, 0, 0, 4'b0000, 8'hA5, 1));
        tbl.push_back(mk(1, 2, 8'hA5, 0, 0, 8'h00, 1, 0, 4'b0000, 8'hA5, 1));
        tbl.push_back(mk(0, 2, 8'hA5, 0, 0, 8'h00, 0, 0, 4'b0000, 8'hA5, 0));
        t1_len = tbl.size();
        // Both requesting continuously after a fresh reset: 0,1,0,1.
        for (int g = 0; g < 4; g++) begin
            logic       w;
            logic [3:0] le_w;
            logic [7:0] ld_w;
            w    = g[0];
            le_w = w ? 4'b1000 : 4'b0001;
            ld_w = w ? 8'hC3 : 8'h5A;
            tbl.push_back(mk(1, 0, 8'h5A, 1, 3, 8'hC3, 0, 0, 4'b0000, ld_w, 1));
            tbl.push_back(mk(1, 0, 8'h5A, 1, 3, 8'hC3, 0, 0, le_w, ld_w, 1));
            tbl.push_back(mk(1, 0, 8'h5A, 1, 3, 8'hC3, 0, 0, 4'b0000, ld_w, 1));
            tbl.push_back(mk(1, 0, 8'h5A, 1, 3, 8'hC3, ~w, w, 4'b0000, ld_w, 1));
            tbl.push_back(mk(g != 3, 0, 8'h5A, g != 3, 3, 8'hC3, 0, 0, 4'b0000, ld_w, 0));
        end

        do_reset();
        a_chk("reset_a", 0, 0, 4'b0000, 8'h00, 0);
        b_chk("reset_b", 0, 0, 3'b000, 8'h00, 0);
`ifdef LATCH_BANK_CTRL_ERR_EN
        chk("reset_a.err", 32'(a_err), 32'd0);
        chk("reset_b.err", 32'(b_err), 32'd0);
`endif

        for (int i = 0; i < t1_len; i++) run_vec(tbl[i], i);
        do_reset();
        for (int i = t1_len; i < tbl.size(); i++) run_vec(tbl[i], i);

        // Reset during ENABLE drops everything; the held request restarts.
        a_req0 = 1; a_addr0 = 1; a_data0 = 8'h77; a_req1 = 0;
        tick(); a_chk("rst.setup", 0, 0, 4'b0000, 8'h77, 1);
        tick(); a_chk("rst.enable", 0, 0, 4'b0010, 8'h77, 1);
        RST = 1'b1;
        tick(); a_chk("rst.forced", 0, 0, 4'b0000, 8'h00, 0);
        RST = 1'b0;
        tick(); a_chk("rst.re_setup", 0, 0, 4'b0000, 8'h77, 1);
        tick(); a_chk("rst.re_enable", 0, 0, 4'b0010, 8'h77, 1);
        tick(); a_chk("rst.re_hold", 0, 0, 4'b0000, 8'h77, 1);
        tick(); a_chk("rst.re_done", 1, 0, 4'b0000, 8'h77, 1);
        a_req0 = 0;
        tick(); a_chk("rst.idle", 0, 0, 4'b0000, 8'h77, 0);

        // Data changed after grant must not reach LD.
        a_req0 = 1; a_addr0 = 1; a_data0 = 8'h11;
        tick(); a_chk("cap.setup", 0, 0, 4'b0000, 8'h11, 1);
        a_data0 = 8'hFF; a_addr0 = 3;
        tick(); a_chk("cap.enable", 0, 0, 4'b0010, 8'h11, 1);
        tick(); a_chk("cap.hold", 0, 0, 4'b0000, 8'h11, 1);
        tick(); a_chk("cap.done", 1, 0, 4'b0000, 8'h11, 1);
        a_req0 = 0;
        tick(); a_chk("cap.idle", 0, 0, 4'b0000, 8'h11, 0);

        // EN_CYC=3 on requester 1: LE held exactly three cycles.
        b_req1 = 1; b_addr1 = 1; b_data1 = 8'h3C;
        tick(); b_chk("b3.setup", 0, 0, 3'b000, 8'h3C, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); b_chk($sformatf("b3.enable%0d", k), 0, 0, 3'b010, 8'h3C, 1);
        end
        tick(); b_chk("b3.hold", 0, 0, 3'b000, 8'h3C, 1);
        tick(); b_chk("b3.done", 0, 1, 3'b000, 8'h3C, 1);
        b_req1 = 0;
        tick(); b_chk("b3.idle", 0, 0, 3'b000, 8'h3C, 0);

        // Out-of-range address (3 with DEPTH=3): no LE, ACK still pulses.
        b_req0 = 1; b_addr0 = 3; b_data0 = 8'h99;
        tick(); b_chk("oob.setup", 0, 0, 3'b000, 8'h99, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); b_chk($sformatf("oob.enable%0d", k), 0, 0, 3'b000, 8'h99, 1);
        end
        tick(); b_chk("oob.hold", 0, 0, 3'b000, 8'h99, 1);
`ifdef LATCH_BANK_CTRL_ERR_EN
        chk("oob.hold.err", 32'(b_err), 32'd0);
`endif
        tick(); b_chk("oob.done", 1, 0, 3'b000, 8'h99, 1);
`ifdef LATCH_BANK_CTRL_ERR_EN
        chk("oob.done.err", 32'(b_err), 32'd1);
`endif
        b_req0 = 0;
        tick(); b_chk("oob.idle", 0, 0, 3'b000, 8'h99, 0);
`ifdef LATCH_BANK_CTRL_ERR_EN
        chk("oob.idle.err", 32'(b_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
